// File: rtl/seven_seg_scanner.sv
// Time-multiplexed scan controller for an up-to-8-digit seven-segment display with
// double-buffered data committed at frame wrap. Optional macro: SEVEN_SEG_LZ_BLANK_EN.
module seven_seg_scanner #(
   parameter int SCAN_DIV   = 100000,
   parameter int NUM_DIGITS = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        wr_en,
   input  logic [31:0] data_in,
   input  logic [7:0]  dp_in,
   input  logic [7:0]  en_mask,
   input  logic        disp_en,
   output logic [3:0]  q,
   output logic [7:0]  an_in,
   output logic        dp_sw,
   output logic [2:0]  digit_idx,
   output logic        frame_done,
   output logic        pending
);

   localparam int             PW       = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
   localparam logic [PW-1:0]  PCNT_MAX = PW'(SCAN_DIV - 1);
   localparam logic [2:0]     IDX_MAX  = 3'(NUM_DIGITS - 1);

   logic [PW-1:0] r_pcnt;
   logic [2:0]    r_idx;
   logic [31:0]   r_shadow_data;
   logic [7:0]    r_shadow_dp;
   logic [31:0]   r_active_data;
   logic [7:0]    r_active_dp;
   logic          r_pending;
   logic          r_frame_done;
   logic [3:0]    r_q;
   logic [7:0]    r_an;
   logic          r_dp;

   logic          w_tick;
   logic          w_wrap;
   logic          w_commit;
   logic [2:0]    w_idx_nxt;
   logic [31:0]   w_act_data_nxt;
   logic [7:0]    w_act_dp_nxt;
   logic          w_blank;
   logic [7:0]    w_an_nxt;

   always_comb begin
      w_tick         = (r_pcnt == PCNT_MAX);
      w_wrap         = w_tick && (r_idx == IDX_MAX);
      w_commit       = w_wrap && r_pending;
      w_idx_nxt      = r_idx;
      if (w_wrap)
         w_idx_nxt = 3'd0;
      else if (w_tick)
         w_idx_nxt = r_idx + 3'd1;
      // outputs are built from the post-commit value so new data shows on the wrap edge
      w_act_data_nxt = w_commit ? r_shadow_data : r_active_data;
      w_act_dp_nxt   = w_commit ? r_shadow_dp   : r_active_dp;
   end

`ifdef SEVEN_SEG_LZ_BLANK_EN
   logic [7:0] w_zero_from;
   logic       w_acc;

   always_comb begin
      w_acc       = 1'b1;
      w_zero_from = 8'h00;
      for (int i = 7; i >= 0; i--) begin
         if (i < NUM_DIGITS)
            w_acc = w_acc & (w_act_data_nxt[4*i +: 4] == 4'h0);
         w_zero_from[i] = w_acc;
      end
      w_blank = (w_idx_nxt != 3'd0) && w_zero_from[w_idx_nxt] && !w_act_dp_nxt[w_idx_nxt];
   end
`else
   assign w_blank = 1'b0;
`endif

   assign w_an_nxt = (disp_en && en_mask[w_idx_nxt] && !w_blank) ? (8'h01 << w_idx_nxt) : 8'h00;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_pcnt        <= '0;
         r_idx         <= 3'd0;
         r_shadow_data <= 32'h0;
         r_shadow_dp   <= 8'h00;
         r_active_data <= 32'h0;
         r_active_dp   <= 8'h00;
         r_pending     <= 1'b0;
         r_frame_done  <= 1'b0;
         r_q           <= 4'h0;
         r_an          <= 8'h00;
         r_dp          <= 1'b0;
      end else begin
         r_pcnt <= w_tick ? '0 : r_pcnt + PW'(1);
         r_idx  <= w_idx_nxt;
         if (w_commit) begin
            r_active_data <= r_shadow_data;
            r_active_dp   <= r_shadow_dp;
         end
         if (wr_en) begin
            r_shadow_data <= data_in;
            r_shadow_dp   <= dp_in;
         end
         r_pending    <= wr_en | (r_pending & ~w_commit);
         r_frame_done <= w_wrap;
         r_q          <= w_act_data_nxt[4*w_idx_nxt +: 4];
         r_an         <= w_an_nxt;
         r_dp         <= disp_en & w_act_dp_nxt[w_idx_nxt];
      end
   end

   assign q          = r_q;
   assign an_in      = r_an;
   assign dp_sw      = r_dp;
   assign digit_idx  = r_idx;
   assign frame_done = r_frame_done;
   assign pending    = r_pending;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Randomized self-checking bench for seven_seg_scanner; the reference model derives
// everything from the edge count since reset. Honors SEVEN_SEG_LZ_BLANK_EN.
module tb_seven_seg_scanner;

   localparam int SD = 4;
   localparam int ND = 8;

   logic        clk;
   logic        rst_n;
   logic        wr_en;
   logic [31:0] data_in;
   logic [7:0]  dp_in;
   logic [7:0]  en_mask;
   logic        disp_en;
   logic [3:0]  q;
   logic [7:0]  an_in;
   logic        dp_sw;
   logic [2:0]  digit_idx;
   logic        frame_done;
   logic        pending;

   seven_seg_scanner #(.SCAN_DIV(SD), .NUM_DIGITS(ND)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .wr_en      (wr_en),
      .data_in    (data_in),
      .dp_in      (dp_in),
      .en_mask    (en_mask),
      .disp_en    (disp_en),
      .q          (q),
      .an_in      (an_in),
      .dp_sw      (dp_sw),
      .digit_idx  (digit_idx),
      .frame_done (frame_done),
      .pending    (pending)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          n_checks = 0;
   int          n_errors = 0;

   // reference state: edges since reset, shadow/active copies, expected outputs
   int          m_k;
   logic [31:0] m_sh;
   logic [7:0]  m_shdp;
   logic [31:0] m_act;
   logic [7:0]  m_actdp;
   logic        m_pend;
   logic        e_fd;
   logic [3:0]  e_q;
   logic [7:0]  e_an;
   logic        e_dp;
   logic [2:0]  e_idx;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, obs, exp, m_k);
      end
   endtask

   task automatic model_edge();
      int  ix;
      bit  wrap;
      bit  blank;
      if (!rst_n) begin
         m_k = 0; m_sh = 0; m_shdp = 0; m_act = 0; m_actdp = 0; m_pend = 0;
         e_fd = 0; e_q = 0; e_an = 0; e_dp = 0; e_idx = 0;
      end else begin
         m_k  = m_k + 1;
         wrap = (m_k % (SD * ND)) == 0;
         if (wrap && m_pend) begin
            m_act   = m_sh;
            m_actdp = m_shdp;
            m_pend  = 0;
         end
         if (wr_en) begin
            m_sh   = data_in;
            m_shdp = dp_in;
            m_pend = 1;
         end
         ix    = (m_k / SD) % ND;
         blank = 0;
`ifdef SEVEN_SEG_LZ_BLANK_EN
         blank = (ix > 0) && ((m_act >> (4 * ix)) == 0) && !m_actdp[ix];
`endif
         e_fd  = wrap;
         e_idx = 3'(ix);
         e_q   = 4'((m_act >> (4 * ix)) & 32'hF);
         e_an  = (disp_en && en_mask[ix] && !blank) ? 8'(1 << ix) : 8'h00;
         e_dp  = disp_en && m_actdp[ix];
      end
   endtask

   task automatic compare();
      chk("q",          32'(q),          32'(e_q));
      chk("an_in",      32'(an_in),      32'(e_an));
      chk("dp_sw",      32'(dp_sw),      32'(e_dp));
      chk("digit_idx",  32'(digit_idx),  32'(e_idx));
      chk("frame_done", 32'(frame_done), 32'(e_fd));
      chk("pending",    32'(pending),    32'(m_pend));
   endtask

   // called at a negedge: drive, let one rising edge happen, check at the next negedge
   task automatic step(input logic wr, input logic [31:0] d, input logic [7:0] dp,
                       input logic [7:0] en, input logic de, input logic rn);
      wr_en   = wr;
      data_in = d;
      dp_in   = dp;
      en_mask = en;
      disp_en = de;
      rst_n   = rn;
      @(posedge clk);
      model_edge();
      @(negedge clk);
      compare();
   endtask

   task automatic idle();
      step(1'b0, 32'h0, 8'h00, en_mask, disp_en, 1'b1);
   endtask

   initial begin
      rst_n = 1'b0; wr_en = 1'b0; data_in = 32'h0; dp_in = 8'h00;
      en_mask = 8'hFF; disp_en = 1'b1; m_k = 0;
      @(negedge clk);
      repeat (3) step(1'b0, 32'h0, 8'h00, 8'hFF, 1'b1, 1'b0);

      // basic scan
      step(1'b1, 32'h8765_4321, 8'h04, 8'hFF, 1'b1, 1'b1);
      repeat (70) idle();

      // tear-free mid-frame write
      while ((m_k % (SD * ND)) != 12) idle();
      step(1'b1, 32'h1111_1111, 8'h00, 8'hFF, 1'b1, 1'b1);
      repeat (40) idle();

      // write landing on the wrap edge while pending
      while ((m_k % (SD * ND)) != 5) idle();
      step(1'b1, 32'hA5A5_0F0F, 8'h81, 8'hFF, 1'b1, 1'b1);
      while (((m_k + 1) % (SD * ND)) != 0) idle();
      step(1'b1, 32'h2468_ACE0, 8'h10, 8'hFF, 1'b1, 1'b1);
      repeat (70) idle();

      // masking then global disable
      step(1'b1, 32'h8765_4321, 8'hFF, 8'hF0, 1'b1, 1'b1);
      repeat (40) idle();
      step(1'b0, 32'h0, 8'h00, 8'hF0, 1'b0, 1'b1);
      repeat (70) idle();
      step(1'b0, 32'h0, 8'h00, 8'hFF, 1'b1, 1'b1);

      // reset mid-frame with pending data
      while (((m_k / SD) % ND) != 5) idle();
      step(1'b1, 32'hDEAD_BEEF, 8'hFF, 8'hFF, 1'b1, 1'b1);
      step(1'b0, 32'h0, 8'h00, 8'hFF, 1'b1, 1'b0);
      repeat (40) idle();

      // leading zeros, then a decimal point on digit 5
      step(1'b1, 32'h0000_0120, 8'h00, 8'hFF, 1'b1, 1'b1);
      repeat (70) idle();
      step(1'b1, 32'h0000_0120, 8'h20, 8'hFF, 1'b1, 1'b1);
      repeat (70) idle();

      // random traffic
      for (int n = 0; n < 900; n++) begin
         logic        wr;
         logic [31:0] d;
         logic [7:0]  en;
         logic        de;
         logic        rn;
         wr = ($urandom_range(0, 7) == 0);
         d  = $urandom & ($urandom_range(0, 1) ? 32'hFFFF_FFFF : 32'h0000_0FFF);
         en = ($urandom_range(0, 15) == 0) ? 8'($urandom) : en_mask;
         de = ($urandom_range(0, 19) == 0) ? ~disp_en : disp_en;
         rn = ($urandom_range(0, 299) != 0);
         step(wr, d, 8'($urandom_range(0, 3) == 0 ? $urandom : 0), en, de, rn);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/seven_seg_scanner.md
# seven_seg_scanner

Time-multiplexed scan controller for the 8-digit seven-segment display. It holds a 32-bit hex value (eight nibbles) plus per-digit decimal points and steps through the digits at a programmable refresh rate. Each step presents one nibble, a one-hot active-high digit enable and a decimal-point request to the downstream segment decoder, which produces the active-low segment and anode lines. New values are double-buffered and take effect only at frame boundaries, so the display never tears.

## Interface
- `SCAN_DIV`, 100000: clocks per digit slot; legal range ≥ 2.
- `NUM_DIGITS`, 8: number of digits scanned; legal range 1..8.
- `clk` in 1: system clock.
- `rst_n` in 1: reset, synchronous, active-low.
- `wr_en` in 1: one-cycle strobe; captures `data_in` and `dp_in` into the shadow registers.
- `data_in` in 32: nibble i drives digit i; digit 0 is `data_in[3:0]`.
- `dp_in` in 8: decimal-point request per digit, active-high.
- `en_mask` in 8: per-digit enable, sampled live (not buffered).
- `disp_en` in 1: global display enable, sampled live.
- `q` out 4: nibble for the current digit.
- `an_in` out 8: one-hot, active-high digit enable.
- `dp_sw` out 1: decimal-point request for the current digit, active-high.
- `digit_idx` out 3: current scan index.
- `frame_done` out 1: one-cycle pulse when the scan index wraps to 0.
- `pending` out 1: shadow registers hold data not yet committed.

## Operation
- **Prescaler** `pcnt`:
  - Counts 0..SCAN_DIV-1 and wraps.
  - `tick` = (`pcnt` == SCAN_DIV-1).
- **Scan index** `idx`:
  - On `tick`, advances by 1.
  - At NUM_DIGITS-1, `tick` wraps it to 0 ("wrap tick").
- **Shadow write**:
  - `wr_en`=1 loads `shadow_data` and `shadow_dp` and sets `pending`=1.
- **Commit**:
  - On a wrap tick with `pending`=1: `active` ← shadow value as it was before the edge; `pending` ← 0.
  - If `wr_en` falls on that same cycle, the shadow takes the new data and `pending` stays 1. The new value commits at the next wrap.
- **`frame_done`**: registered; equals 1 exactly in the cycle after a wrap tick.
- **Output registers** (updated every cycle from the post-update `idx` and `active`):
  - `q` = `active_data[4*idx +: 4]`.
  - `dp_sw` = `active_dp[idx]`.
  - `an_in` = (1 << idx) when `disp_en` & `en_mask[idx]` & not blanked; otherwise 8'h00.
  - `an_in` bits ≥ NUM_DIGITS are always 0.
- **Disabled display**: `disp_en`=0 forces `an_in`=0 and `dp_sw`=0. Scanning, commits and `frame_done` continue.
- **Reset** (`rst_n`=0 at a clock edge): `pcnt`, `idx`, shadow and active registers, `pending`, `frame_done`, `q`, `an_in`, `dp_sw` and `digit_idx` all become 0. A reset mid-frame discards any pending data.

## Timing
- **First output after reset**: the first edge with `rst_n`=1 registers digit 0. `an_in`=8'h01 if `disp_en` and `en_mask[0]` are 1.
- **Digit slot length**: exactly SCAN_DIV clocks.
- **Frame length**: NUM_DIGITS × SCAN_DIV clocks.
- **Index-to-output**: outputs change on the same edge that `idx` changes.
  - `digit_idx` mirrors `idx`.
  - `an_in` is never multi-hot. Between slots it moves directly from one bit to the next.
- **Write latency**: from the `wr_en` edge to visible data is between 1 and NUM_DIGITS × SCAN_DIV clocks, i.e. up to the next wrap tick. The new value appears on the edge of that wrap.
- **Live inputs**: changes to `en_mask` and `disp_en` take effect on the next edge.
- **NUM_DIGITS=1**: every tick is a wrap tick and `idx` is always 0.

## Configuration
- **`SEVEN_SEG_LZ_BLANK_EN`** defined: leading-zero blanking.
  - Digit i > 0 is blanked (`an_in`=0 for that slot) when all nibbles i..NUM_DIGITS-1 of `active_data` are 0 and `active_dp[i]`=0.
  - Digit 0 is never blanked.
- **Undefined**: no blanking; every enabled digit is lit, including leading zeros.

## Test plan
- **Reset and basic scan** (SCAN_DIV=4, NUM_DIGITS=8):
  - Stimulus: reset, then `wr_en` with `data_in`=32'h8765_4321, `dp_in`=8'h04, `en_mask`=8'hFF, `disp_en`=1.
  - Required: after the first wrap, `q` steps 1,2,…,8 every 4 clocks, `an_in` steps 01,02,…,80, and `dp_sw`=1 only while `idx`=2.
- **Tear-free commit**:
  - Stimulus: write 32'h1111_1111 mid-frame.
  - Required: `q` keeps the old values until the wrap tick; `pending`=1 until then; `frame_done` pulses once on the commit.
- **Write on the wrap cycle**:
  - Stimulus: `wr_en` coincident with a wrap tick while `pending`=1.
  - Required: the old shadow value commits, the new value commits one frame later, and `pending` stays 1 across the first wrap.
- **Masking and disable**:
  - Stimulus: `en_mask`=8'hF0, then `disp_en`=0.
  - Required: `an_in`=0 during slots 0–3; with `disp_en`=0, `an_in`=0 and `dp_sw`=0 while `digit_idx` keeps cycling and `frame_done` keeps pulsing.
- **Reset mid-frame**:
  - Stimulus: assert `rst_n`=0 for one edge with `pending`=1 and `idx`=5.
  - Required: all outputs and `pending` are 0; scanning restarts at `idx`=0.
- **`SEVEN_SEG_LZ_BLANK_EN`**:
  - Stimulus: data 32'h0000_0120, `dp_in`=0.
  - Required: digits 3–7 are blanked; digits 0–2 are lit, showing 0, 2, 1.
  - Stimulus: setting `dp_in[5]`.
  - Required: digit 5 lights (`q`=0).
